// File: rtl/sc_lsu.sv
// sc_lsu: load/store unit between the single-cycle core and the word-organised data memory.
// Optional misalignment trap: define SC_LSU_MISALIGN_TRAP_EN; otherwise low address bits are masked.
module sc_lsu (
   input  logic        clk,
   input  logic        clrn,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_win,
   input  logic [31:0] mem_rout
);

   typedef enum logic [2:0] {IDLE, LOAD, STW, RMW_RD, RMW_WR, DONE, ERR} state_t;

   state_t      state;
   logic [1:0]  size_q;
   logic        sext_q;
   logic [1:0]  alo_q;
   logic [15:0] wd_q;

   logic        is_word;
   logic        misaligned;
   logic [31:0] eff_addr;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_val;
   logic [31:0] merged;

   // Size 11 behaves as a word access.
   assign is_word = size[1];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      eff_addr   = addr;
      misaligned = 1'b0;
`ifdef SC_LSU_MISALIGN_TRAP_EN
      misaligned = (is_word && (addr[1:0] != 2'b00)) || ((size == 2'b01) && addr[0]);
`else
      if (is_word)
         eff_addr[1:0] = 2'b00;
      else if (size == 2'b01)
         eff_addr[0] = 1'b0;
`endif
   end

   assign lane_b = mem_rout[{alo_q, 3'b000} +: 8];
   assign lane_h = alo_q[1] ? mem_rout[31:16] : mem_rout[15:0];

   always_comb begin
      case (size_q)
         2'b00:   load_val = {{24{sext_q & lane_b[7]}}, lane_b};
         2'b01:   load_val = {{16{sext_q & lane_h[15]}}, lane_h};
         default: load_val = mem_rout;
      endcase
   end

   // Read-modify-write: only the addressed lane takes the new data.
   always_comb begin
      merged = mem_rout;
      case (size_q)
         2'b00:   merged[{alo_q, 3'b000} +: 8]     = wd_q[7:0];
         2'b01:   merged[{alo_q[1], 4'b0000} +: 16] = wd_q;
         default: merged = mem_rout;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state    <= IDLE;
         rdata    <= '0;
         mem_addr <= '0;
         mem_win  <= '0;
         size_q   <= '0;
         sext_q   <= 1'b0;
         alo_q    <= '0;
         wd_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  size_q <= size;
                  sext_q <= sext;
                  alo_q  <= eff_addr[1:0];
                  wd_q   <= wdata[15:0];
                  if (misaligned) begin
                     state <= ERR;
                  end else begin
                     mem_addr <= {eff_addr[31:2], 2'b00};
                     if (!we) begin
                        state <= LOAD;
                     end else if (is_word) begin
                        state   <= STW;
                        mem_win <= wdata;
                     end else begin
                        state <= RMW_RD;
                     end
                  end
               end
            end
            LOAD: begin
               rdata <= load_val;
               state <= DONE;
            end
            STW:    state <= DONE;
            RMW_RD: begin
               mem_win <= merged;
               state   <= RMW_WR;
            end
            RMW_WR: state <= DONE;
            DONE:   state <= IDLE;
            ERR:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Decoded from state so a reset drops mem_wen without waiting for a clock.
   assign ready   = (state == IDLE);
   assign done    = (state == DONE) || (state == ERR);
   assign mem_wen = (state == STW) || (state == RMW_WR);
`ifdef SC_LSU_MISALIGN_TRAP_EN
   assign err = (state == ERR);
`else
   assign err = 1'b0;
`endif

endmodule
